// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: state encoding and default widths.
package counter_pkg;

    localparam int STATE_W      = 3;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_STEP_W   = 4;

    // Operation applied at the last clock edge.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        DEC  = 3'b011,
        SAT  = 3'b100
    } state_e;

endpackage

// File: rtl/cnt_ns_logic_n.sv
// Next-state / next-count / next-overflow decode for the up/down counter.
// Purely combinational: depends only on the current inputs and count, so an
// out-of-range state register value is naturally flushed on the next edge.
module cnt_ns_logic_n
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic               en,
    input  logic               load,
    input  logic               inc,
    input  logic               sat_mode,
    input  logic [STEP_W-1:0]  step,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [WIDTH-1:0]   count,
    output logic [STATE_W-1:0] next_state,
    output logic [WIDTH-1:0]   next_count,
    output logic               next_ovf
);

    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Step widened by one bit so bit WIDTH of sum/diff is the carry/borrow.
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum      = {1'b0, count} + step_ext;
    assign diff     = {1'b0, count} - step_ext;

    // Priority: enable gate, then load, then count up/down with wrap or clamp.
    always_comb begin
        next_state = IDLE;
        next_count = count;
        next_ovf   = 1'b0;
        if (en) begin
            if (load) begin
                next_state = LOAD;
                next_count = d_in;
            end else if (inc) begin
                next_state = INC;
                next_count = sum[WIDTH-1:0];
                if (sum[WIDTH]) begin
                    next_ovf = 1'b1;
                    if (sat_mode) begin
                        next_state = SAT;
                        next_count = '1;
                    end
                end
            end else begin
                next_state = DEC;
                next_count = diff[WIDTH-1:0];
                if (diff[WIDTH]) begin
                    next_ovf = 1'b1;
                    if (sat_mode) begin
                        next_state = SAT;
                        next_count = '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// Loadable up/down counter with programmable step, wrap/saturate policy,
// registered operation state and overflow flag, and boundary decodes.
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               load,
    input  logic               inc,
    input  logic               sat_mode,
    input  logic [STEP_W-1:0]  step,
    input  logic [WIDTH-1:0]   d_in,
    output logic [WIDTH-1:0]   count,
    output logic [STATE_W-1:0] state,
    output logic               ovf,
    output logic               at_max,
    output logic               at_min
);

    logic [WIDTH-1:0]   count_d, count_q;
    logic [STATE_W-1:0] state_d, state_q;
    logic               ovf_d,   ovf_q;

    cnt_ns_logic_n #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_ns (
        .en         (en),
        .load       (load),
        .inc        (inc),
        .sat_mode   (sat_mode),
        .step       (step),
        .d_in       (d_in),
        .count      (count_q),
        .next_state (state_d),
        .next_count (count_d),
        .next_ovf   (ovf_d)
    );

    // Count, state and overflow update together; reset clears them at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            state_q <= IDLE;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    // Boundary flags follow the registered count in the same cycle.
    always_comb begin
        at_max = (count_q == {WIDTH{1'b1}});
        at_min = (count_q == '0);
    end

    assign count = count_q;
    assign state = state_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench for updown_counter_n: the driver queues the expected
// registered outputs with each stimulus; the monitor checks them after edges.
module tb_updown_counter_n;

    localparam int W  = 8;
    localparam int SW = 4;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LOAD = 3'b001;
    localparam logic [2:0] S_INC  = 3'b010;
    localparam logic [2:0] S_DEC  = 3'b011;
    localparam logic [2:0] S_SAT  = 3'b100;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          en = 1'b0, load = 1'b0, inc = 1'b0, sat_mode = 1'b0;
    logic [SW-1:0] step = '0;
    logic [W-1:0]  d_in = '0;
    logic [W-1:0]  count;
    logic [2:0]    state;
    logic          ovf, at_max, at_min;

    typedef struct {
        logic [W-1:0] cnt;
        logic [2:0]   st;
        logic         ovf;
        logic         mx;
        logic         mn;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    updown_counter_n #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .load     (load),
        .inc      (inc),
        .sat_mode (sat_mode),
        .step     (step),
        .d_in     (d_in),
        .count    (count),
        .state    (state),
        .ovf      (ovf),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [W-1:0] c, input logic [2:0] s,
                        input logic o, input logic mx, input logic mn,
                        input string name);
        exp_t e;
        e.cnt = c; e.st = s; e.ovf = o; e.mx = mx; e.mn = mn; e.name = name;
        sb_q.push_back(e);
    endtask

    // One clocked operation: drive at negedge, queue the post-edge result.
    task automatic op(input logic e_en, input logic e_ld, input logic e_inc,
                      input logic e_sat, input logic [SW-1:0] e_step,
                      input logic [W-1:0] e_d, input logic [W-1:0] x_cnt,
                      input logic [2:0] x_st, input logic x_ovf,
                      input logic x_mx, input logic x_mn, input string name);
        @(negedge clk);
        en = e_en; load = e_ld; inc = e_inc; sat_mode = e_sat;
        step = e_step; d_in = e_d;
        push(x_cnt, x_st, x_ovf, x_mx, x_mn, name);
    endtask

    // Monitor: after every clock edge or reset assertion, drain and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (count !== e.cnt || state !== e.st || ovf !== e.ovf ||
                    at_max !== e.mx || at_min !== e.mn) begin
                    bad++;
                    $display("FAIL %s: got cnt=%h st=%b ovf=%b max=%b min=%b, exp cnt=%h st=%b ovf=%b max=%b min=%b",
                             e.name, count, state, ovf, at_max, at_min,
                             e.cnt, e.st, e.ovf, e.mx, e.mn);
                end
            end
        end
    end

    initial begin
        // power-on reset
        #1;
        push(8'h00, S_IDLE, 1'b0, 1'b0, 1'b1, "reset_init");
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        //  en ld inc sat step   d_in   cnt    state   ovf  mx  mn
        op(0, 0, 0, 0, 4'd0, 8'h00, 8'h00, S_IDLE, 0, 0, 1, "idle_after_reset");
        op(1, 1, 0, 0, 4'd0, 8'h37, 8'h37, S_LOAD, 0, 0, 0, "load_37");
        op(1, 0, 1, 0, 4'd1, 8'h00, 8'h38, S_INC,  0, 0, 0, "inc_38");

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        push(8'h00, S_IDLE, 1'b0, 1'b0, 1'b1, "reset_mid");
        reset_n = 1'b0;
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        op(0, 0, 1, 0, 4'd1, 8'h00, 8'h00, S_IDLE, 0, 0, 1, "hold_after_release");

        // wrap up by 3
        op(1, 1, 0, 0, 4'd0, 8'hF0, 8'hF0, S_LOAD, 0, 0, 0, "load_F0");
        op(1, 0, 1, 0, 4'd3, 8'h00, 8'hF3, S_INC,  0, 0, 0, "wrap_F3");
        op(1, 0, 1, 0, 4'd3, 8'h00, 8'hF6, S_INC,  0, 0, 0, "wrap_F6");
        op(1, 0, 1, 0, 4'd3, 8'h00, 8'hF9, S_INC,  0, 0, 0, "wrap_F9");
        op(1, 0, 1, 0, 4'd3, 8'h00, 8'hFC, S_INC,  0, 0, 0, "wrap_FC");
        op(1, 0, 1, 0, 4'd3, 8'h00, 8'hFF, S_INC,  0, 1, 0, "wrap_FF");
        op(1, 0, 1, 0, 4'd3, 8'h00, 8'h02, S_INC,  1, 0, 0, "wrap_02");

        // saturate up, persist, leave
        op(1, 1, 0, 1, 4'd0, 8'hFA, 8'hFA, S_LOAD, 0, 0, 0, "load_FA");
        op(1, 0, 1, 1, 4'd15, 8'h00, 8'hFF, S_SAT, 1, 1, 0, "sat_up");
        op(1, 0, 1, 1, 4'd15, 8'h00, 8'hFF, S_SAT, 1, 1, 0, "sat_up_again");
        op(1, 0, 0, 1, 4'd1, 8'h00, 8'hFE, S_DEC,  0, 0, 0, "leave_sat_FE");

        // wrap and saturate down
        op(1, 1, 0, 0, 4'd0, 8'h01, 8'h01, S_LOAD, 0, 0, 0, "load_01");
        op(1, 0, 0, 0, 4'd2, 8'h00, 8'hFF, S_DEC,  1, 1, 0, "wrap_down_FF");
        op(1, 1, 0, 1, 4'd0, 8'h01, 8'h01, S_LOAD, 0, 0, 0, "load_01b");
        op(1, 0, 0, 1, 4'd2, 8'h00, 8'h00, S_SAT,  1, 0, 1, "sat_down_00");
        op(0, 0, 0, 1, 4'd2, 8'h00, 8'h00, S_IDLE, 0, 0, 1, "sat_to_idle");

        // load priority and enable gating
        op(1, 1, 1, 0, 4'd5, 8'h5A, 8'h5A, S_LOAD, 0, 0, 0, "load_prio_5A");
        op(0, 1, 0, 0, 4'd0, 8'h11, 8'h5A, S_IDLE, 0, 0, 0, "gated_load");

        // zero step and plain decrement
        op(1, 1, 0, 0, 4'd0, 8'h80, 8'h80, S_LOAD, 0, 0, 0, "load_80");
        op(1, 0, 1, 0, 4'd0, 8'h00, 8'h80, S_INC,  0, 0, 0, "zero_step_80");
        op(1, 0, 0, 0, 4'd5, 8'h00, 8'h7B, S_DEC,  0, 0, 0, "dec_7B");
        op(1, 1, 0, 1, 4'd0, 8'hFF, 8'hFF, S_LOAD, 0, 1, 0, "load_FF");
        op(1, 0, 1, 1, 4'd0, 8'h00, 8'hFF, S_INC,  0, 1, 0, "zero_step_FF_sat");
        op(1, 1, 0, 1, 4'd0, 8'h00, 8'h00, S_LOAD, 0, 0, 1, "load_00");
        op(1, 0, 0, 1, 4'd0, 8'h00, 8'h00, S_DEC,  0, 0, 1, "zero_step_00_sat");
        op(1, 0, 1, 0, 4'd15, 8'h00, 8'h0F, S_INC, 0, 0, 0, "inc_0F");

        // drain: every queued expectation must have been checked
        repeat (3) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending=%0d, exp pending=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
